// File: rtl/voice_allocator_if.sv
// Event handshake and per-voice control bus of the voice allocator.
interface voice_allocator_if #(
    parameter int VOICES         = 8,
    parameter int NOTE_WIDTH     = 7,
    parameter int VELOCITY_WIDTH = 7
);
    logic                               event_valid;
    logic                               event_ready;
    logic                               event_note_on;
    logic [NOTE_WIDTH-1:0]              event_note;
    logic [VELOCITY_WIDTH-1:0]          event_velocity;
    logic [VOICES-1:0]                  voice_gate;
    logic [VOICES*NOTE_WIDTH-1:0]       voice_note;
    logic [VOICES*VELOCITY_WIDTH-1:0]   voice_velocity;
    logic [VOICES-1:0]                  voice_trigger;
    logic [VOICES-1:0]                  voice_release;
    logic                               event_dropped;

    modport master (
        output event_valid, event_note_on, event_note, event_velocity,
        input  event_ready, voice_gate, voice_note, voice_velocity,
               voice_trigger, voice_release, event_dropped
    );

    modport slave (
        input  event_valid, event_note_on, event_note, event_velocity,
        output event_ready, voice_gate, voice_note, voice_velocity,
               voice_trigger, voice_release, event_dropped
    );
endinterface

// File: rtl/voice_allocator.sv
// Sequential-scan polyphonic voice allocator (retrigger > lowest free > oldest).
// VOICE_ALLOCATOR_STEAL_EN: steal the oldest voice instead of dropping when full.
module voice_allocator #(
    parameter int VOICES         = 8,
    parameter int NOTE_WIDTH     = 7,
    parameter int VELOCITY_WIDTH = 7
) (
    input  logic             clock_50_000_000,
    input  logic             reset,
    voice_allocator_if.slave bus
);
    localparam int              IW   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0]   LAST = IW'(VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

    state_e                                 state_q;
    logic                                   ready_q;
    logic [IW-1:0]                          idx_q;
    logic                                   ev_on_q;
    logic [NOTE_WIDTH-1:0]                  ev_note_q;
    logic [VELOCITY_WIDTH-1:0]              ev_vel_q;
    logic                                   has_match_q, has_free_q;
    logic [IW-1:0]                          match_q, free_q, old_q;
    logic [VOICES-1:0]                      gate_q, trig_q, rel_q;
    logic                                   drop_q;
    logic [VOICES-1:0][NOTE_WIDTH-1:0]      note_q;
    logic [VOICES-1:0][VELOCITY_WIDTH-1:0]  vel_q;
    logic [VOICES-1:0][IW-1:0]              rank_q;

    logic [IW-1:0]                          tgt_d;
    logic                                   tgt_vld_d;

    assign bus.event_ready    = ready_q;
    assign bus.voice_gate     = gate_q;
    assign bus.voice_note     = note_q;
    assign bus.voice_velocity = vel_q;
    assign bus.voice_trigger  = trig_q;
    assign bus.voice_release  = rel_q;
    assign bus.event_dropped  = drop_q;

    // Note-on target after the scan; the oldest voice is only usable when stealing.
    always_comb begin
        tgt_d     = old_q;
        tgt_vld_d = 1'b0;
        if (has_match_q) begin
            tgt_d     = match_q;
            tgt_vld_d = 1'b1;
        end else if (has_free_q) begin
            tgt_d     = free_q;
            tgt_vld_d = 1'b1;
        end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
            tgt_vld_d = 1'b1;
`else
            tgt_vld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            idx_q       <= '0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_vel_q    <= '0;
            has_match_q <= 1'b0;
            has_free_q  <= 1'b0;
            match_q     <= '0;
            free_q      <= '0;
            old_q       <= '0;
            gate_q      <= '0;
            trig_q      <= '0;
            rel_q       <= '0;
            drop_q      <= 1'b0;
            note_q      <= '0;
            vel_q       <= '0;
            for (int i = 0; i < VOICES; i++) rank_q[i] <= IW'(i);
        end else begin
            trig_q <= '0;
            rel_q  <= '0;
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.event_valid && ready_q) begin
                        // Velocity-0 note-on is a note-off in MIDI running status.
                        ev_on_q     <= bus.event_note_on && (bus.event_velocity != '0);
                        ev_note_q   <= bus.event_note;
                        ev_vel_q    <= bus.event_velocity;
                        has_match_q <= 1'b0;
                        has_free_q  <= 1'b0;
                        idx_q       <= '0;
                        ready_q     <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (gate_q[idx_q] && note_q[idx_q] == ev_note_q && !has_match_q) begin
                        has_match_q <= 1'b1;
                        match_q     <= idx_q;
                    end
                    if (!gate_q[idx_q] && !has_free_q) begin
                        has_free_q <= 1'b1;
                        free_q     <= idx_q;
                    end
                    if (rank_q[idx_q] == LAST) old_q <= idx_q;
                    if (idx_q == LAST) state_q <= COMMIT;
                    else               idx_q   <= idx_q + 1'b1;
                end
                COMMIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    if (ev_on_q && tgt_vld_d) begin
                        gate_q[tgt_d] <= 1'b1;
                        note_q[tgt_d] <= ev_note_q;
                        vel_q[tgt_d]  <= ev_vel_q;
                        trig_q[tgt_d] <= 1'b1;
                        for (int i = 0; i < VOICES; i++) begin
                            if (IW'(i) == tgt_d)                rank_q[i] <= '0;
                            else if (rank_q[i] < rank_q[tgt_d]) rank_q[i] <= rank_q[i] + 1'b1;
                        end
                    end else if (ev_on_q) begin
                        drop_q <= 1'b1;
                    end else if (has_match_q) begin
                        gate_q[match_q] <= 1'b0;
                        rel_q[match_q]  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed table-driven bench for voice_allocator (VOICES=8).
module tb_voice_allocator;
    localparam int V = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    voice_allocator_if #(.VOICES(V), .NOTE_WIDTH(7), .VELOCITY_WIDTH(7)) bus ();

    voice_allocator #(.VOICES(V), .NOTE_WIDTH(7), .VELOCITY_WIDTH(7)) dut (
        .clock_50_000_000 (clk),
        .reset            (rst),
        .bus              (bus)
    );

    typedef struct {
        bit         rst;
        bit         on;
        logic [6:0] note;
        logic [6:0] vel;
        logic [7:0] trig;
        logic [7:0] rel;
        bit         drop;
        logic [7:0] gate;
        int         cv;
        logic [6:0] cnote;
        logic [6:0] cvel;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit on, int note, int vel, int trig, int rel, bit drop,
                                int gate, int cv, int cnote, int cvel);
        vec_t x;
        x.rst = r; x.on = on; x.note = 7'(note); x.vel = 7'(vel);
        x.trig = 8'(trig); x.rel = 8'(rel); x.drop = drop; x.gate = 8'(gate);
        x.cv = cv; x.cnote = 7'(cnote); x.cvel = 7'(cvel);
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply(input int k, input vec_t x);
        int  n;
        bit  busy_ok;
        n = 0;
        bus.event_valid    = 1'b1;
        bus.event_note_on  = x.on;
        bus.event_note     = x.note;
        bus.event_velocity = x.vel;
        while (!bus.event_ready && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) chk($sformatf("v%0d ready_wait", k), 0, 1);
        @(posedge clk); #1;
        // Inputs are only sampled at the accept edge; scramble them afterwards.
        bus.event_valid    = 1'b0;
        bus.event_note_on  = ~x.on;
        bus.event_note     = 7'h7f;
        bus.event_velocity = 7'h55;
        busy_ok = 1'b1;
        for (int c = 1; c <= V + 1; c++) begin
            @(negedge clk);
            if (bus.event_ready !== 1'b0) busy_ok = 1'b0;
            if (bus.voice_trigger !== '0 || bus.voice_release !== '0) busy_ok = 1'b0;
        end
        chk($sformatf("v%0d busy", k), {31'd0, busy_ok}, 1);
        @(negedge clk);
        chk($sformatf("v%0d trig", k),  bus.voice_trigger, x.trig);
        chk($sformatf("v%0d rel", k),   bus.voice_release, x.rel);
        chk($sformatf("v%0d drop", k),  bus.event_dropped, x.drop);
        chk($sformatf("v%0d gate", k),  bus.voice_gate, x.gate);
        chk($sformatf("v%0d note", k),  bus.voice_note[x.cv*7 +: 7], x.cnote);
        chk($sformatf("v%0d vel", k),   bus.voice_velocity[x.cv*7 +: 7], x.cvel);
        chk($sformatf("v%0d ready", k), bus.event_ready, 1);
        @(negedge clk);
        chk($sformatf("v%0d strobe_clr", k),
            {bus.voice_trigger, bus.voice_release, bus.event_dropped}, 0);
    endtask

    initial begin
        bit seen;
        bus.event_valid    = 1'b0;
        bus.event_note_on  = 1'b0;
        bus.event_note     = '0;
        bus.event_velocity = '0;

        // Basic allocation, release, retrigger, note-off miss, velocity-0 note-on.
        vt.push_back(mk(1, 1, 60, 100, 8'h01, 0,     0, 8'h01, 0, 60, 100));
        vt.push_back(mk(0, 1, 62,  90, 8'h02, 0,     0, 8'h03, 1, 62,  90));
        vt.push_back(mk(0, 1, 64,  80, 8'h04, 0,     0, 8'h07, 2, 64,  80));
        vt.push_back(mk(0, 0, 62,  33, 0,     8'h02, 0, 8'h05, 1, 62,  90));
        vt.push_back(mk(0, 1, 67,  70, 8'h02, 0,     0, 8'h07, 1, 67,  70));
        vt.push_back(mk(0, 1, 60,  20, 8'h01, 0,     0, 8'h07, 0, 60,  20));
        vt.push_back(mk(0, 0, 99,  10, 0,     0,     0, 8'h07, 0, 60,  20));
        vt.push_back(mk(0, 1, 60,   0, 0,     8'h01, 0, 8'h06, 0, 60,  20));
        // Fill all voices from reset with 60..67.
        for (int k = 0; k < V; k++)
            vt.push_back(mk(k == 0, 1, 60 + k, 100, 1 << k, 0, 0, (1 << (k + 1)) - 1, k, 60 + k, 100));
`ifdef VOICE_ALLOCATOR_STEAL_EN
        vt.push_back(mk(0, 1, 70, 50, 8'h01, 0, 0, 8'hff, 0, 70, 50));
        vt.push_back(mk(0, 1, 71, 51, 8'h02, 0, 0, 8'hff, 1, 71, 51));
`else
        vt.push_back(mk(0, 1, 70, 50, 0, 0, 1, 8'hff, 0, 60, 100));
        vt.push_back(mk(0, 1, 71, 51, 0, 0, 1, 8'hff, 1, 61, 100));
`endif
        vt.push_back(mk(0, 0, 65, 0,  0,     8'h20, 0, 8'hdf, 5, 65, 100));
        vt.push_back(mk(0, 1, 72, 40, 8'h20, 0,     0, 8'hff, 5, 72,  40));

        do_reset();
        chk("rst gate",  bus.voice_gate, 0);
        chk("rst ready", bus.event_ready, 1);
        chk("rst note",  bus.voice_note, 0);
        chk("rst vel",   bus.voice_velocity, 0);
        chk("rst strobes", {bus.voice_trigger, bus.voice_release, bus.event_dropped}, 0);

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            apply(i, vt[i]);
        end

        // Reset during the scan of a note-on with all voices held.
        @(negedge clk);
        bus.event_valid    = 1'b1;
        bus.event_note_on  = 1'b1;
        bus.event_note     = 7'd80;
        bus.event_velocity = 7'd90;
        @(posedge clk); #1;
        bus.event_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst gate",  bus.voice_gate, 0);
        chk("midrst ready", bus.event_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst ready_after", bus.event_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.voice_trigger !== '0 || bus.voice_gate !== '0 || bus.event_dropped !== 1'b0)
                seen = 1'b1;
        end
        chk("midrst no_trigger", {31'd0, seen}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the MIDI decoder and the per-voice oscillator/envelope datapath. It accepts decoded note-on and note-off events one at a time, scans a fixed pool of voices sequentially, and assigns each event to a voice. Assignment priority is retrigger of the same note, then the lowest free voice, then the least-recently-assigned voice. It drives per-voice note, velocity, gate and one-cycle trigger/release strobes that the synthesis datapath consumes on its sample clock domain via its own synchronisers.

## Interface
Parameters:
- VOICES, 8: number of voices; power of two, 2..16.
- NOTE_WIDTH, 7: MIDI note number width.
- VELOCITY_WIDTH, 7: MIDI velocity width.

Ports:
- clock_50_000_000  in  1  system clock; the only clock of this block.
- reset  in  1  asynchronous, active-high reset.
- event_valid  in  1  event present.
- event_ready  out  1  block can accept an event.
- event_note_on  in  1  1 = note-on, 0 = note-off.
- event_note  in  NOTE_WIDTH  note number.
- event_velocity  in  VELOCITY_WIDTH  velocity.
- voice_gate  out  VOICES  voice currently held.
- voice_note  out  VOICES*NOTE_WIDTH  per-voice note; voice i occupies bits [i*NOTE_WIDTH +: NOTE_WIDTH].
- voice_velocity  out  VOICES*VELOCITY_WIDTH  per-voice velocity, packed the same way.
- voice_trigger  out  VOICES  one-cycle strobe: voice (re)started.
- voice_release  out  VOICES  one-cycle strobe: voice released.
- event_dropped  out  1  one-cycle strobe: note-on discarded.

## Operation
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: event_ready=1. An accepted event (valid&&ready at an edge) is latched and the FSM goes to SCAN with index 0.
  - SCAN: one voice is examined per cycle, index 0..VOICES-1, with event_ready=0. After index VOICES-1 the FSM goes to COMMIT.
  - COMMIT: apply the decision, then return to IDLE.
- Note-on with velocity 0 is treated as a note-off.
- During the scan, record the lowest-index voice in each of three categories:
  - match: gated and note equal to the event note.
  - free: not gated.
  - oldest: rank = VOICES-1.
- Note-on target: match if one exists, else free, else oldest (steal; see Configuration).
  - Target gets gate=1, note and velocity loaded, and a trigger pulse.
- Note-off: if a match exists, that voice gets gate=0 and a release pulse. Note and velocity are retained. Otherwise nothing changes and there is no strobe.
- Rank (internal, clog2(VOICES) bits per voice, 0 = newest) forms a permutation.
  - On each note-on assignment to voice v with rank r, every voice with rank < r increments and v takes rank 0.
  - Note-offs and drops leave ranks unchanged.
- Reset values:
  - State IDLE; event_ready=1.
  - All gate, trigger, release and event_dropped = 0.
  - voice_note and voice_velocity all 0.
  - Rank of voice i = i.

## Timing
- Edge 0 accepts the event. SCAN occupies cycles 1..VOICES. COMMIT is cycle VOICES+1.
- Gate, note and velocity registers update on the edge ending COMMIT.
- Trigger, release and dropped strobes are high for exactly the following cycle, which is IDLE with event_ready=1.
- Throughput: one event per VOICES+2 cycles. Event inputs are sampled only at the accept edge and may change afterwards.
- At most one bit of voice_trigger or voice_release is high in any cycle, never both. event_dropped is never concurrent with a trigger.
- All outputs are registered. Nothing is combinational from the event inputs except via the latch.
- Reset asserted mid-SCAN or mid-COMMIT: the in-flight event is discarded, all reset values apply immediately, and no strobe is emitted.

## Configuration
- VOICE_ALLOCATOR_STEAL_EN defined: a note-on with no match and no free voice steals the oldest voice.
  - Note, velocity and trigger are applied to it; gate stays 1; rank becomes 0.
  - No release strobe on the stolen voice.
- Not defined: the same case leaves all voices unchanged and pulses event_dropped for one cycle.
- Priority and behaviour are otherwise identical in both builds.

## Test plan
- Reset then note-on note 60, velocity 100 → voice 0 gate=1, note=60, velocity=100; voice_trigger=8'h01 exactly 10 cycles after the accept edge (VOICES=8); event_ready low for cycles 1..9.
- Note-on 60, 62, 64, then note-off 62 → voice 1 gate=0, voice_release=8'h02; voices 0 and 2 still gated; next note-on 67 lands in voice 1.
- Note-on 60 twice, second with velocity 20 → second event retriggers voice 0 with velocity 20, trigger=8'h01, voice 1 stays free.
- Fill 8 voices with notes 60..67, then note-on 70 → with STEAL_EN: voice 0 (oldest) note=70, trigger=8'h01, no release; without it: event_dropped pulse, all voices unchanged.
- Note-off 99 with nothing held, and note-on 60 velocity 0 while 60 is held → first causes no strobes or changes; second releases voice 0.
- Assert reset during SCAN of a note-on → all gates 0, no trigger ever emitted, event_ready=1 one cycle after reset release.
